// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_pkg
// Purpose  : Shared constants and run-control state encoding for the
//            instruction-fetch stage.
// Contents : NOP_INSTR, HALT_INSTR, PC_STEP, if_state_e (2-bit FSM encoding)
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } if_state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory
// Purpose  : Word-addressed instruction store, written by the debug unit.
// Ports    : clk                  - clock (write port)
//            i_wr_en/addr/data    - synchronous write port
//            i_rd_addr            - asynchronous read word index
//            o_rd_data            - read data
// Revision : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int NB_DATA    = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int NB_IADDR   = 8
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [NB_IADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]  i_wr_data,
    input  logic [NB_IADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0]  o_rd_data
);

    // Contents are deliberately not reset: the program survives a core reset.
    logic [NB_DATA-1:0] r_mem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : MIPS IF stage: PC register, next-PC mux, run-control FSM,
//            instruction memory and IF/ID pipeline register.
// Ports    : clk, i_rst (sync, active-high)
//            i_wr_en/i_wr_addr/i_wr_data  - debug-unit memory load (IDLE only)
//            i_start, i_step_mode, i_step - run control
//            i_stall                      - hazard-unit hold
//            i_jump/i_jump_addr, i_branch_taken/i_branch_addr - redirects
//            o_instruction, o_pcounter4, o_valid - IF/ID register
//            o_pc, o_halted               - debug readout
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int NB_IADDR   = 8
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic                i_wr_en,
    input  logic [NB_IADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]  i_wr_data,
    input  logic                i_start,
    input  logic                i_step_mode,
    input  logic                i_step,
    input  logic                i_stall,
    input  logic                i_jump,
    input  logic [NB_DATA-1:0]  i_jump_addr,
    input  logic                i_branch_taken,
    input  logic [NB_DATA-1:0]  i_branch_addr,
    output logic [NB_DATA-1:0]  o_instruction,
    output logic [NB_DATA-1:0]  o_pcounter4,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_pc,
    output logic                o_halted
);

    if_state_e          r_state;
    if_state_e          w_state_next;
    logic               w_active;      // RUN or STEP: redirects honoured
    logic               w_fetch;       // this cycle loads IF/ID from memory
    logic               w_redirect;
    logic               w_halt_fetch;
    logic               w_imem_wr_en;
    logic [NB_DATA-1:0] w_rd_data;
    logic [NB_DATA-1:0] w_pc_plus4;

    logic [NB_DATA-1:0] r_pc;
    logic [NB_DATA-1:0] r_instruction;
    logic [NB_DATA-1:0] r_pcounter4;
    logic               r_valid;

    // Program loading is only safe while the core is parked.
    assign w_imem_wr_en = i_wr_en && (r_state == ST_IDLE);
    assign w_pc_plus4   = r_pc + NB_DATA'(PC_STEP);

    instruction_memory #(
        .NB_DATA    (NB_DATA),
        .IMEM_DEPTH (IMEM_DEPTH),
        .NB_IADDR   (NB_IADDR)
    ) u_imem (
        .clk        (clk),
        .i_wr_en    (w_imem_wr_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_rd_addr  (r_pc[NB_IADDR+1:2]),
        .o_rd_data  (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_active     = 1'b0;
        w_fetch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = i_step_mode ? ST_STEP : ST_RUN;
                end
            end
            ST_RUN: begin
                w_active = 1'b1;
                w_fetch  = !i_stall;
            end
            ST_STEP: begin
                w_active = 1'b1;
                w_fetch  = i_step && !i_stall;
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_redirect   = w_active && (i_jump || i_branch_taken);
        // A redirect squashes the fetched word, so it cannot halt the core.
        w_halt_fetch = w_fetch && !w_redirect && (w_rd_data == NB_DATA'(HALT_INSTR));
        if (w_halt_fetch) begin
            w_state_next = ST_HALTED;
        end
    end

    // ------------------------------------------------------------------
    // PC and IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_pc          <= '0;
            r_instruction <= NB_DATA'(NOP_INSTR);
            r_pcounter4   <= '0;
            r_valid       <= 1'b0;
        end else if (w_redirect) begin
            // Redirect overrides stall and missing step pulse.
            r_pc          <= i_jump ? i_jump_addr : i_branch_addr;
            r_instruction <= NB_DATA'(NOP_INSTR);
            r_pcounter4   <= '0;
            r_valid       <= 1'b0;
        end else if (w_fetch) begin
            // The HALT word itself drains down the pipe; PC parks on it.
            if (!w_halt_fetch) begin
                r_pc <= w_pc_plus4;
            end
            r_instruction <= w_rd_data;
            r_pcounter4   <= w_pc_plus4;
            r_valid       <= 1'b1;
        end else if (!w_active) begin
            // IDLE and HALTED feed bubbles to decode.
            r_instruction <= NB_DATA'(NOP_INSTR);
            r_pcounter4   <= '0;
            r_valid       <= 1'b0;
        end
        // Otherwise stalled in RUN/STEP: everything holds.
    end

    assign o_instruction = r_instruction;
    assign o_pcounter4   = r_pcounter4;
    assign o_valid       = r_valid;
    assign o_pc          = r_pc;
    assign o_halted      = (r_state == ST_HALTED);

endmodule
`default_nettype wire
